// File: rtl/demux2_if.sv
// Bundle of the demux2 input stream, both output streams and the delivery
// counters. The slave view belongs to the demux; the master view belongs to
// whatever produces words and consumes the two ports.
interface demux2_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             s1;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [7:0]       a_count;
    logic [7:0]       b_count;

    modport slave (
        input  din, din_valid, s1, a_ready, b_ready,
        output din_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );

    modport master (
        output din, din_valid, s1, a_ready, b_ready,
        input  din_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );
endinterface

// File: rtl/demux2.sv
// 1-to-2 stream demultiplexer. Each accepted word is routed by s1 into a
// two-entry FIFO in front of port a (s1=0) or port b (s1=1). Index 0 of every
// per-port array is port a, index 1 is port b. Words leave each port in order,
// and a wrapping 8-bit counter per port tallies deliveries.
module demux2 #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    demux2_if.slave  bus
);
    localparam int DEPTH = 2;

    logic [WIDTH-1:0] mem_q  [2][DEPTH];
    logic [WIDTH-1:0] mem_d  [2][DEPTH];
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       occ_q  [2];
    logic [1:0]       occ_d  [2];
    logic [7:0]       dcnt_q [2];
    logic [7:0]       dcnt_d [2];

    logic [1:0] sel;
    logic [1:0] port_ready;
    logic [1:0] push;
    logic [1:0] pop;
    logic       din_ready_int;
    logic       accept;

    // Readiness looks only at the occupancy of the buffer the current select
    // points at; held low throughout reset so nothing is taken.
    assign din_ready_int = rst_n && (occ_q[bus.s1] != 2'(DEPTH));
    assign accept        = bus.din_valid && din_ready_int;

    assign sel        = {bus.s1, ~bus.s1};
    assign port_ready = {bus.b_ready, bus.a_ready};

    // Next-state for both buffers: write at tail on push, advance head on pop.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        dcnt_d   = dcnt_q;
        push     = 2'b00;
        pop      = 2'b00;
        for (int p = 0; p < 2; p++) begin
            push[p] = accept && sel[p];
            pop[p]  = (occ_q[p] != 2'd0) && port_ready[p];
            if (push[p]) begin
                mem_d[p][wr_ptr_q[p]] = bus.din;
                wr_ptr_d[p]           = ~wr_ptr_q[p];
            end
            if (pop[p]) begin
                rd_ptr_d[p] = ~rd_ptr_q[p];
                dcnt_d[p]   = dcnt_q[p] + 8'd1;
            end
            if (push[p] && !pop[p]) begin
                occ_d[p] = occ_q[p] + 2'd1;
            end else if (pop[p] && !push[p]) begin
                occ_d[p] = occ_q[p] - 2'd1;
            end
        end
    end

    // State registers; reset empties both buffers and zeroes the storage so
    // the data outputs read 0 while held in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[p][e] <= '0;
                end
                occ_q[p]  <= 2'd0;
                dcnt_q[p] <= 8'd0;
            end
            rd_ptr_q <= 2'b00;
            wr_ptr_q <= 2'b00;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign bus.din_ready = din_ready_int;
    assign bus.a_data    = mem_q[0][rd_ptr_q[0]];
    assign bus.a_valid   = (occ_q[0] != 2'd0);
    assign bus.b_data    = mem_q[1][rd_ptr_q[1]];
    assign bus.b_valid   = (occ_q[1] != 2'd0);
    assign bus.a_count   = dcnt_q[0];
    assign bus.b_count   = dcnt_q[1];
endmodule

// File: doc/demux2.md
DEMUX2 -- requirements
Module: demux2

Interface
REQ-001 Parameter: WIDTH, default 8, data width of the input and both output ports.
REQ-002 Parameter: DEPTH, fixed at 2, entries per output buffer; not overridable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 din  input  WIDTH  input data word.
REQ-006 din_valid  input  1  din holds a valid word.
REQ-007 din_ready  output  1  demux can accept the word on din this cycle.
REQ-008 s1  input  1  route select, sampled with the word: 0 -> port a, 1 -> port b.
REQ-009 a_data  output  WIDTH  head word of port-a buffer.
REQ-010 a_valid  output  1  port-a buffer non-empty.
REQ-011 a_ready  input  1  port-a consumer takes a_data this cycle.
REQ-012 b_data / b_valid / b_ready  output / output / input  WIDTH / 1 / 1  port-b equivalents of REQ-009..011.
REQ-013 a_count  output  8  words delivered on port a, modulo 256.
REQ-014 b_count  output  8  words delivered on port b, modulo 256.

Function
REQ-015 Transfer rules: input accepted when din_valid and din_ready are both high; port-a word delivered when a_valid and a_ready are both high; port-b likewise.
REQ-016 din_ready is combinational: high iff the buffer selected by the current s1 holds fewer than 2 words; it depends only on that occupancy, not on same-cycle a_ready/b_ready.
REQ-017 An accepted word is written to the tail of the selected buffer only; the other buffer is unchanged.
REQ-018 Latency: a word accepted at edge N is visible on the selected port's data/valid outputs from edge N onward, i.e. 1 cycle after presentation; there is no combinational path from din to the outputs.
REQ-019 Each buffer is FIFO: words leave a port in acceptance order; ordering between ports is independent.
REQ-020 x_data equals the head entry while x_valid=1; its value is don't-care while x_valid=0.
REQ-021 Per-buffer occupancy is 0, 1 or 2:
- push only: +1.
- pop only: -1.
- push and pop same cycle: unchanged, and the head advances.
REQ-022 Full buffer (2 words): din_ready=0 for that select even if that port's ready is high the same cycle; a pop frees the slot for the next cycle.
REQ-023 Empty buffer: x_valid=0, and x_ready is ignored with no underflow.
REQ-024 s1 may change every cycle; each word is routed by the s1 value in its own acceptance cycle.
REQ-025 din_valid=0: no write, regardless of s1 or din.
REQ-026 a_count increments by 1 on each port-a delivery and wraps 255 -> 0; b_count behaves identically for port b.
REQ-027 Throughput: sustained 1 word/cycle to one port when that port's ready is held high.

Reset
REQ-028 rst_n=0 immediately, without waiting for a clock edge:
- clears both buffers to empty.
- forces a_valid=b_valid=0.
- forces a_data=b_data=0.
- clears a_count=b_count=0.
REQ-029 While rst_n=0, din_ready=0 and no word is accepted.
REQ-030 Reset asserted mid-operation discards all buffered words; none appear after reset release.
REQ-031 First acceptance is possible at the first rising edge after rst_n deasserts.

Verification
REQ-032 Reset and route: rst_n low, then high; din=8'hA5, s1=0, din_valid=1 for 1 cycle, a_ready=0 -> next cycle a_valid=1, a_data=8'hA5; b_valid=0; counts remain 0.
REQ-033 Backpressure: s1=0, a_ready=0, send 8'h01, 8'h02, 8'h03 -> din_ready drops after the second word; 8'h03 is held; a_ready=1 then delivers 01, 02, 03 in order; a_count=3.
REQ-034 Alternating select: s1 toggles each cycle, a_ready=b_ready=1, send 8'h10..8'h17 -> port a delivers 10, 12, 14, 16 and port b delivers 11, 13, 15, 17; a_count=b_count=4.
REQ-035 Simultaneous push/pop: port-a buffer holds 1 word, push 8'h55 on s1=0 with a_ready=1 in the same cycle -> occupancy stays 1 and a_data=8'h55 next cycle.
REQ-036 Independence and wrap: port a full with a_ready=0, s1=1 -> din_ready=1 and port b accepts; separately, 256 deliveries on port b -> b_count returns to 0.
REQ-037 Reset mid-operation: both buffers full, pull rst_n low between clock edges -> a_valid=b_valid=0 immediately; after release both ports stay empty until new input.
